exit_uart_reporter: RTL
=======================

EXIT_UART_REPORTER -- requirements
Module: exit_uart_reporter

Interface
REQ-001 SHALL have parameter CLK_FREQ_HZ, default 50000000, meaning the clk_i frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115200, meaning the UART bit rate.
REQ-003 SHALL have port clk_i  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_i  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port exit_valid_i  input  1  the core's exit strobe or level; sampled on each clock.
REQ-006 SHALL have port exit_value_i  input  32  the core's exit code, qualified by exit_valid_i.
REQ-007 SHALL have port uart_tx_o  output  1  8N1 serial line; idles high.
REQ-008 SHALL have port busy_o  output  1  high while a report is being transmitted.
REQ-009 SHALL have port done_o  output  1  sticky; high once the report has been fully sent.
REQ-010 SHALL have port exit_code_o  output  32  the captured exit value.
REQ-011 SHALL have port pass_o  output  1  done_o AND (exit_code_o == 0).

Function
REQ-012 SHALL derive CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE (truncating), and SHALL fail elaboration if CLKS_PER_BIT < 2.
REQ-013 SHALL use the states IDLE, START, DATA, STOP, NEXT and DONE.
REQ-014 In IDLE, on the first clock with exit_valid_i=1, SHALL capture exit_value_i into exit_code_o, set busy_o, and go to START on the next cycle.
REQ-015 SHALL ignore exit_valid_i in every state other than IDLE; only one capture per reset, even if valid stays high or re-pulses.
REQ-016 SHALL send the message ASCII "EXIT=" + 8 uppercase hex digits of exit_code_o (MSB nibble first) + terminator (REQ-030/031).
REQ-017 Hex mapping: nibble 0-9 SHALL map to 0x30-0x39, and A-F SHALL map to 0x41-0x46.
REQ-018 Each character SHALL be framed as 1 start bit (0), then 8 data bits LSB first, then 1 stop bit (1).
REQ-019 Each bit SHALL last exactly CLKS_PER_BIT cycles, timed by a down-counter reloaded at every bit boundary.
REQ-020 uart_tx_o SHALL go low on the first cycle the FSM is in START, which is one cycle after capture.
REQ-021 The NEXT state SHALL last one cycle with uart_tx_o=1; it SHALL advance the character index, then go to START, or to DONE after the last character.
REQ-022 Consecutive characters SHALL therefore be separated by CLKS_PER_BIT+1 cycles of stop-level line.
REQ-023 In DONE, busy_o SHALL be 0, done_o SHALL be 1, and uart_tx_o SHALL be 1; the block SHALL stay in DONE until reset.
REQ-024 uart_tx_o SHALL be registered (glitch-free), and exit_code_o SHALL be stable from capture onward.
REQ-025 The character index SHALL never exceed message length-1; there is no wrap-around.

Reset
REQ-026 rst_i high SHALL immediately (asynchronously) force the state to IDLE and set uart_tx_o=1, busy_o=0, done_o=0, exit_code_o=0 and pass_o=0.
REQ-027 A reset asserted mid-frame SHALL abort the frame with no further bits sent; after release, the block SHALL rearm for a new capture.
REQ-028 Reset release SHALL be synchronized internally; the first capture is possible on the second clock after rst_i falls.
REQ-029 If exit_valid_i=1 on the first armed cycle, the block SHALL capture it.

Configuration
REQ-030 With macro EXIT_UART_REPORTER_CRLF_EN defined, the terminator SHALL be CR LF (0x0D 0x0A), giving a 15-character message.
REQ-031 Without EXIT_UART_REPORTER_CRLF_EN, the terminator SHALL be LF only (0x0A), giving a 14-character message; nothing else changes.

Verification
REQ-032 Reset scenario: CLK_FREQ_HZ=1000000, BAUD_RATE=100000, assert rst_i -> uart_tx_o=1, busy_o=0, done_o=0, exit_code_o=0.
REQ-033 Pass scenario: one-cycle exit_valid_i with value 0x0000002A, CRLF_EN defined -> decoded "EXIT=0000002A\r\n".
  - each bit lasts 10 cycles; the start bit begins 1 cycle after capture.
  - done_o rises after 15 frames; pass_o=0.
REQ-034 Fail-code scenario: value 0xDEADBEEF with valid held high for 500 cycles -> exactly one message, "EXIT=DEADBEEF" plus terminator, with uppercase hex.
REQ-035 Ignore scenario: value 0x00000000, then a second valid with 0x00000005 during transmission -> exit_code_o stays 0, pass_o=1 at done, and one message only.
REQ-036 Mid-frame reset scenario: assert rst_i during character 3 -> uart_tx_o=1 in the same cycle; after a new valid with 0x1, a complete fresh "EXIT=00000001" message follows.
REQ-037 No-CRLF scenario: macro undefined, value 0x0 -> 14 frames, the last being 0x0A, and done_o after the 14th stop bit.

Source files
------------

// File: rtl/exit_uart_reporter.sv
// Transmits "EXIT=" + 8 hex digits of the captured exit code + terminator over an 8N1 UART.
// Define EXIT_UART_REPORTER_CRLF_EN for a CR LF terminator (15 chars); default is LF only (14 chars).
module exit_uart_reporter #(
    parameter int CLK_FREQ_HZ = 50000000,
    parameter int BAUD_RATE   = 115200
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        exit_valid_i,
    input  logic [31:0] exit_value_i,
    output logic        uart_tx_o,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] exit_code_o,
    output logic        pass_o
);

    localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
    localparam int CW = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] RELOAD = CW'(CLKS_PER_BIT - 1);
`ifdef EXIT_UART_REPORTER_CRLF_EN
    localparam int MSG_LEN = 15;
`else
    localparam int MSG_LEN = 14;
`endif
    localparam logic [3:0] CHAR_LAST = 4'(MSG_LEN - 1);

    generate
        if (CLKS_PER_BIT < 2) begin : g_bad_baud
            $error("exit_uart_reporter: CLK_FREQ_HZ / BAUD_RATE must be at least 2");
        end
    endgenerate

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, NEXT, DONE} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  baudCnt_q, baudCnt_d;
    logic [2:0]     bitIdx_q, bitIdx_d;
    logic [3:0]     charIdx_q, charIdx_d;
    logic [31:0]    exitCode_q, exitCode_d;
    logic           txLine_q, txLine_d;
    logic           armed_q;
    logic [7:0]     curChar;

    // Message character at a given index; hex digits are taken MSB nibble first.
    function automatic logic [7:0] charAt(input logic [3:0] idx, input logic [31:0] code);
        logic [31:0] shifted;
        logic [3:0]  nib;
        shifted = code << {(idx - 4'd5), 2'b00};
        nib     = shifted[31:28];
        charAt  = 8'h0A;
        case (idx)
            4'd0:  charAt = 8'h45;
            4'd1:  charAt = 8'h58;
            4'd2:  charAt = 8'h49;
            4'd3:  charAt = 8'h54;
            4'd4:  charAt = 8'h3D;
            4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12:
                charAt = (nib < 4'd10) ? (8'h30 + {4'b0, nib}) : (8'h37 + {4'b0, nib});
`ifdef EXIT_UART_REPORTER_CRLF_EN
            4'd13: charAt = 8'h0D;
`endif
            default: charAt = 8'h0A;
        endcase
    endfunction

    // Release of rst_i passes through one flop, so capture is first possible on the second clock.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) armed_q <= 1'b0;
        else       armed_q <= 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            baudCnt_q  <= '0;
            bitIdx_q   <= '0;
            charIdx_q  <= '0;
            exitCode_q <= '0;
            txLine_q   <= 1'b1;
        end else begin
            state_q    <= state_d;
            baudCnt_q  <= baudCnt_d;
            bitIdx_q   <= bitIdx_d;
            charIdx_q  <= charIdx_d;
            exitCode_q <= exitCode_d;
            txLine_q   <= txLine_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        baudCnt_d  = baudCnt_q;
        bitIdx_d   = bitIdx_q;
        charIdx_d  = charIdx_q;
        exitCode_d = exitCode_q;
        case (state_q)
            IDLE: begin
                if (armed_q && exit_valid_i) begin
                    exitCode_d = exit_value_i;
                    state_d    = START;
                    baudCnt_d  = RELOAD;
                    bitIdx_d   = '0;
                    charIdx_d  = '0;
                end
            end
            START: begin
                if (baudCnt_q == '0) begin
                    state_d   = DATA;
                    baudCnt_d = RELOAD;
                    bitIdx_d  = '0;
                end else begin
                    baudCnt_d = baudCnt_q - CW'(1);
                end
            end
            DATA: begin
                if (baudCnt_q == '0) begin
                    baudCnt_d = RELOAD;
                    if (bitIdx_q == 3'd7) state_d = STOP;
                    else                  bitIdx_d = bitIdx_q + 3'd1;
                end else begin
                    baudCnt_d = baudCnt_q - CW'(1);
                end
            end
            STOP: begin
                if (baudCnt_q == '0) state_d = NEXT;
                else                 baudCnt_d = baudCnt_q - CW'(1);
            end
            NEXT: begin
                if (charIdx_q == CHAR_LAST) begin
                    state_d = DONE;
                end else begin
                    charIdx_d = charIdx_q + 4'd1;
                    state_d   = START;
                    baudCnt_d = RELOAD;
                end
            end
            DONE:    state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // The line level is computed from the next state so the registered output lines up with it.
    always_comb begin
        curChar  = charAt(charIdx_d, exitCode_q);
        txLine_d = 1'b1;
        case (state_d)
            START:   txLine_d = 1'b0;
            DATA:    txLine_d = curChar[bitIdx_d];
            default: txLine_d = 1'b1;
        endcase
    end

    assign uart_tx_o   = txLine_q;
    assign busy_o      = (state_q != IDLE) && (state_q != DONE);
    assign done_o      = (state_q == DONE);
    assign exit_code_o = exitCode_q;
    assign pass_o      = done_o && (exitCode_q == 32'd0);

endmodule
